// File: rtl/led_pwm_driver_if.sv
// Bus interface for led_pwm_driver.
//   LED_IN    : raw 3-bit LED pattern from the upstream counter stage
//   BTN_N     : raw active-low brightness pushbutton (asynchronous, bouncing)
//   LED_OUT   : PWM-dimmed LED drive (registered, active-high)
//   LEVEL_OUT : current brightness level 0..7 (registered)
// master = the side that drives the pattern and the button; slave = the driver.
interface led_pwm_driver_if;
    logic [2:0] LED_IN;
    logic       BTN_N;
    logic [2:0] LED_OUT;
    logic [2:0] LEVEL_OUT;

    modport master (
        output LED_IN,
        output BTN_N,
        input  LED_OUT,
        input  LEVEL_OUT
    );

    modport slave (
        input  LED_IN,
        input  BTN_N,
        output LED_OUT,
        output LEVEL_OUT
    );
endinterface

// File: rtl/led_pwm_driver.sv
// LED PWM driver with debounced brightness button.
// A pushbutton steps an 8-level brightness (wraps 7 -> 0). The LED pattern
// and duty cycle are latched only at PWM period boundaries, so the dimmed
// output never glitches mid-period.
// Ports:
//   CLK_IN  : system clock, all state on the rising edge
//   RESET_N : synchronous active-low reset
//   bus     : slave modport of led_pwm_driver_if (LED_IN, BTN_N in;
//             LED_OUT, LEVEL_OUT out)
module led_pwm_driver #(
    parameter int PWM_BITS        = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                   CLK_IN,
    input  logic                   RESET_N,
    led_pwm_driver_if.slave        bus
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DCNT_W-1:0]   DCNT_MAX  = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCNT_W-1:0]   DCNT_ONE  = DCNT_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);
    localparam logic [PWM_BITS:0]   DUTY_ONE  = (PWM_BITS+1)'(1);
    localparam logic [PWM_BITS:0]   DUTY_FULL = DUTY_ONE << PWM_BITS;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // On-time in counts for a level: (level+1)/8 of the period.
    function automatic logic [PWM_BITS:0] duty_of(input logic [2:0] lvl);
        logic [PWM_BITS:0] steps;
        steps = {{(PWM_BITS-2){1'b0}}, lvl} + DUTY_ONE;
        return steps << (PWM_BITS - 3);
    endfunction

    // Synchronizer stores the inverted button so that 1 means pressed.
    logic                sync_p0;
    logic                sync_p1;
    logic                btn_s;

    state_t              state;
    logic [DCNT_W-1:0]   dcnt;
    logic [2:0]          level;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [2:0]          led_lat;
    logic [PWM_BITS:0]   duty_lat;
    logic [2:0]          led_out_r;

    assign btn_s         = sync_p1;
    assign bus.LED_OUT   = led_out_r;
    assign bus.LEVEL_OUT = level;

    // Stage: button synchronizer
    always_ff @(posedge CLK_IN) begin
        if (!RESET_N) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= ~bus.BTN_N;
            sync_p1 <= sync_p0;
        end
    end

    // Stage: debounce FSM and brightness level
    always_ff @(posedge CLK_IN) begin
        if (!RESET_N) begin
            state <= IDLE;
            dcnt  <= '0;
            level <= 3'd7;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        dcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (dcnt == DCNT_MAX) begin
                        state <= PRESSED;
                        level <= level + 3'd1;  // wraps 7 -> 0
                    end else begin
                        dcnt <= dcnt + DCNT_ONE;
                    end
                end
                PRESSED: begin
                    // Holding the button never auto-repeats.
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        dcnt  <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= PRESSED;
                    end else if (dcnt == DCNT_MAX) begin
                        state <= IDLE;
                    end else begin
                        dcnt <= dcnt + DCNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stage: PWM counter, period-boundary latches and output compare
    always_ff @(posedge CLK_IN) begin
        if (!RESET_N) begin
            pwm_cnt   <= '0;
            led_lat   <= '0;
            duty_lat  <= DUTY_FULL;
            led_out_r <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_ONE;
            // Latch at the wrap only; uses the level as it stands before any
            // same-edge increment, which then takes effect next period.
            if (pwm_cnt == '1) begin
                led_lat  <= bus.LED_IN;
                duty_lat <= duty_of(level);
            end
            led_out_r <= led_lat & {3{({1'b0, pwm_cnt} < duty_lat)}};
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
module tb_led_pwm_driver;
    localparam int PB   = 4;
    localparam int DEB  = 4;
    localparam int NPER = 1 << PB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errs   = 0;
    int   checks = 0;
    bit   chk_on = 0;

    led_pwm_driver_if bus ();

    led_pwm_driver #(
        .PWM_BITS        (PB),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLK_IN  (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: period-based PWM and run-length debounce.
    int          m_ph;
    int          m_duty;
    int          m_run;
    logic [2:0]  m_lat;
    logic [2:0]  m_led;
    logic [2:0]  m_lvl;
    logic        m_s0, m_s1, m_deb, m_bs;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ph = 0; m_duty = NPER; m_run = 0;
            m_lat = 3'b000; m_led = 3'b000; m_lvl = 3'd7;
            m_s0 = 1'b0; m_s1 = 1'b0; m_deb = 1'b0;
        end else begin
            m_bs  = m_s1;
            m_led = (m_ph < m_duty) ? m_lat : 3'b000;
            if (m_ph == NPER - 1) begin
                m_lat  = bus.LED_IN;
                m_duty = (int'(m_lvl) + 1) * NPER / 8;
            end
            m_ph = (m_ph + 1) % NPER;
            // A change is accepted after DEB+1 consecutive differing samples.
            if (m_bs != m_deb) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_deb = m_bs;
                    m_run = 0;
                    if (m_bs) m_lvl = m_lvl + 3'd1;
                end
            end else begin
                m_run = 0;
            end
            m_s1 = m_s0;
            m_s0 = ~bus.BTN_N;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("led_cycle", 32'(bus.LED_OUT), 32'(m_led));
            chk("lvl_cycle", 32'(bus.LEVEL_OUT), 32'(m_lvl));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic count_on(output int n);
        n = 0;
        repeat (NPER) begin
            @(negedge clk);
            if (bus.LED_OUT != 3'b000) n++;
        end
    endtask

    task automatic press(input int lo, input int hi);
        bus.BTN_N = 1'b0;
        cyc(lo);
        bus.BTN_N = 1'b1;
        cyc(hi);
    endtask

    initial begin
        int  n;
        bit  found;
        bus.LED_IN = 3'b101;
        bus.BTN_N  = 1'b1;

        // Reset state
        cyc(2);
        chk_on = 1;
        chk("rst_level", 32'(bus.LEVEL_OUT), 32'd7);
        chk("rst_led", 32'(bus.LED_OUT), 32'd0);
        rst_n = 1'b1;

        // LED_OUT stays dark until the first wrap latches LED_IN
        cyc(16);
        chk("pre_wrap", 32'(bus.LED_OUT), 32'd0);
        cyc(1);
        chk("first_wrap", 32'(bus.LED_OUT), 32'b101);
        cyc(10);
        chk("steady_101", 32'(bus.LED_OUT), 32'b101);

        // One long press: 7 -> 0, then 2 of 16 cycles on
        press(20, 20);
        chk("step_to_0", 32'(bus.LEVEL_OUT), 32'd0);
        count_on(n);
        chk("on_lvl0", 32'(n), 32'd2);

        // Bounce is rejected
        do_reset();
        bus.BTN_N = 1'b0; cyc(2);
        bus.BTN_N = 1'b1; cyc(1);
        bus.BTN_N = 1'b0; cyc(2);
        bus.BTN_N = 1'b1; cyc(20);
        chk("bounce_lvl", 32'(bus.LEVEL_OUT), 32'd7);

        // Eight clean presses walk through every level
        do_reset();
        for (int i = 0; i < 8; i++) begin
            press(12, 12 + $urandom_range(0, 8));
            cyc(20);
            chk("seq_lvl", 32'(bus.LEVEL_OUT), 32'(i));
            count_on(n);
            chk("seq_on", 32'(n), 32'(2 * (i + 1)));
        end

        // LED_IN change mid-period only shows after the next wrap
        bus.LED_IN = 3'b001;
        cyc(20);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (m_ph == 5) found = 1;
        end
        chk("find_phase5", 32'(found), 32'd1);
        bus.LED_IN = 3'b110;
        cyc(11);
        chk("old_pattern", 32'(bus.LED_OUT), 32'b001);
        cyc(1);
        chk("new_pattern", 32'(bus.LED_OUT), 32'b110);

        // Random LED_IN patterns with random presses, checked cycle by cycle
        for (int i = 0; i < 6; i++) begin
            bus.LED_IN = 3'($urandom_range(0, 7));
            press($urandom_range(1, 12), $urandom_range(1, 12));
            cyc($urandom_range(0, 20));
        end
        bus.BTN_N = 1'b1;
        cyc(20);

        // Reset in PRESS_WAIT with dcnt=2 abandons the press
        do_reset();
        bus.LED_IN = 3'b111;
        bus.BTN_N  = 1'b0;
        cyc(5);
        rst_n     = 1'b0;
        bus.BTN_N = 1'b1;
        cyc(1);
        chk("midpress_rst_lvl", 32'(bus.LEVEL_OUT), 32'd7);
        chk("midpress_rst_led", 32'(bus.LED_OUT), 32'd0);
        rst_n = 1'b1;
        cyc(30);
        chk("no_step_after", 32'(bus.LEVEL_OUT), 32'd7);

        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
